// File: rtl/objects_mux_pkg.sv
// Shared constants and helpers for the layered objects priority mux.
package objects_mux_pkg;

  localparam int DEF_COLOR_W = 8;
  localparam logic [DEF_COLOR_W-1:0] DEF_TRANSPARENT_RGB = 8'hFF;
  localparam logic [DEF_COLOR_W-1:0] BLACK_RGB = 8'h00;

  // Largest supported layer count; rgb_slice works on a bus padded to this size.
  localparam int MAX_LAYERS = 16;

  // Returns colour slice idx of a packed colour bus (layer i at [i*W +: W]).
  function automatic logic [DEF_COLOR_W-1:0] rgb_slice(
    input logic [MAX_LAYERS*DEF_COLOR_W-1:0] packed_rgb,
    input int unsigned                       idx
  );
    return packed_rgb[idx*DEF_COLOR_W +: DEF_COLOR_W];
  endfunction

endpackage

// File: rtl/layer_priority_encoder.sv
// Finds the lowest-numbered active layer (index 0 is highest priority).
module layer_priority_encoder #(
  parameter int N_LAYERS = 8,
  parameter int IDX_W    = $clog2(N_LAYERS)
) (
  input  logic [N_LAYERS-1:0] active,
  output logic [IDX_W-1:0]    idx,
  output logic                hit
);

  // Scan from the top down so the lowest active index is the last one written.
  always_comb begin
    idx = '0;
    hit = |active;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (active[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/layered_objects_mux.sv
// Layered priority mux with transparency keying, background colour,
// a 2-stage pipeline and per-frame layer overlap flags.
//
// Handshake: pixel_valid_in qualifies the inputs of the current cycle and
// pixel_valid_out qualifies rgb_out/winner_* exactly two cycles later. There
// is no ready/back-pressure; one pixel is accepted every cycle.
module layered_objects_mux
  import objects_mux_pkg::*;
#(
  parameter int                 N_LAYERS        = 8,
  parameter int                 COLOR_W         = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] TRANSPARENT_RGB = COLOR_W'(DEF_TRANSPARENT_RGB),
  parameter int                 IDX_W           = $clog2(N_LAYERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pixel_valid_in,
  input  logic                        start_of_frame,
  input  logic [N_LAYERS-1:0]         draw_req,
  input  logic [N_LAYERS*COLOR_W-1:0] rgb_in,
  input  logic [N_LAYERS-1:0]         layer_en,
  input  logic [COLOR_W-1:0]          bg_rgb,
  output logic [COLOR_W-1:0]          rgb_out,
  output logic                        pixel_valid_out,
  output logic [IDX_W-1:0]            winner_idx,
  output logic                        winner_hit,
  output logic [N_LAYERS-1:0]         collision_flags,
  output logic                        frame_done
);

  logic [N_LAYERS-1:0]         active_d;
  logic [1:0]                  pop_sat;
  logic                        multi_d;

  logic [N_LAYERS-1:0]         act_q;
  logic [N_LAYERS*COLOR_W-1:0] rgb_q;
  logic [COLOR_W-1:0]          bg_q;
  logic                        vld_q;
  logic                        sof_q;
  logic                        multi_q;

  logic [IDX_W-1:0]            enc_idx;
  logic                        enc_hit;
  logic [COLOR_W-1:0]          sel_rgb;
  logic [N_LAYERS-1:0]         acc;

  // Layer activity and a popcount that saturates at 2 (only "two or more" matters).
  always_comb begin
    active_d = '0;
    pop_sat  = 2'd0;
    for (int i = 0; i < N_LAYERS; i++) begin
      active_d[i] = draw_req[i] & layer_en[i] &
                    (rgb_in[i*COLOR_W +: COLOR_W] != TRANSPARENT_RGB);
      if (active_d[i] && (pop_sat != 2'd2)) pop_sat = pop_sat + 2'd1;
    end
    multi_d = (pop_sat == 2'd2);
  end

  // Stage 1: capture the pixel and its precomputed activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q   <= '0;
      rgb_q   <= '0;
      bg_q    <= '0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      act_q   <= active_d;
      rgb_q   <= rgb_in;
      bg_q    <= bg_rgb;
      vld_q   <= pixel_valid_in;
      sof_q   <= start_of_frame;
      multi_q <= multi_d;
    end
  end

  layer_priority_encoder #(
    .N_LAYERS (N_LAYERS),
    .IDX_W    (IDX_W)
  ) u_enc (
    .active (act_q),
    .idx    (enc_idx),
    .hit    (enc_hit)
  );

  // Colour of the winning layer; the package helper covers the default width.
  if (COLOR_W == DEF_COLOR_W) begin : g_pkg_slice
    logic [MAX_LAYERS*DEF_COLOR_W-1:0] rgb_wide;
    // Pad the layer bus to the helper's fixed size.
    always_comb begin
      rgb_wide = '0;
      rgb_wide[N_LAYERS*COLOR_W-1:0] = rgb_q;
    end
    assign sel_rgb = rgb_slice(rgb_wide, 32'(enc_idx));
  end else begin : g_direct_slice
    assign sel_rgb = rgb_q[enc_idx*COLOR_W +: COLOR_W];
  end

  // Stage 2: output colour/winner and the per-frame overlap accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out         <= COLOR_W'(BLACK_RGB);
      pixel_valid_out <= 1'b0;
      winner_idx      <= '0;
      winner_hit      <= 1'b0;
      acc             <= '0;
      collision_flags <= '0;
      frame_done      <= 1'b0;
    end else begin
      rgb_out         <= enc_hit ? sel_rgb : bg_q;
      pixel_valid_out <= vld_q;
      winner_idx      <= enc_hit ? enc_idx : '0;
      winner_hit      <= enc_hit;
      if (sof_q) begin
        // Publish the previous frame; the start pixel seeds the new frame.
        collision_flags <= acc;
        frame_done      <= 1'b1;
        acc             <= (vld_q & multi_q) ? act_q : '0;
      end else begin
        frame_done <= 1'b0;
        if (vld_q & multi_q) acc <= acc | act_q;
      end
    end
  end

endmodule

// File: tb/tb_layered_objects_mux.sv
// Scoreboard bench for layered_objects_mux: directed frames plus random streaming.
module tb_layered_objects_mux;
  import objects_mux_pkg::*;

  localparam int N  = 8;
  localparam int CW = 8;
  localparam int IW = 3;
  localparam logic [CW-1:0] TRANS = 8'hFF;
  localparam int EW = 32 + 1 + IW + CW;
  localparam int FW = 32 + N;

  logic          clk = 1'b0;
  logic          reset;
  logic          pixel_valid_in;
  logic          start_of_frame;
  logic [N-1:0]  draw_req;
  logic [N*CW-1:0] rgb_in;
  logic [N-1:0]  layer_en;
  logic [CW-1:0] bg_rgb;
  logic [CW-1:0] rgb_out;
  logic          pixel_valid_out;
  logic [IW-1:0] winner_idx;
  logic          winner_hit;
  logic [N-1:0]  collision_flags;
  logic          frame_done;

  layered_objects_mux #(
    .N_LAYERS (N),
    .COLOR_W  (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pixel_valid_in  (pixel_valid_in),
    .start_of_frame  (start_of_frame),
    .draw_req        (draw_req),
    .rgb_in          (rgb_in),
    .layer_en        (layer_en),
    .bg_rgb          (bg_rgb),
    .rgb_out         (rgb_out),
    .pixel_valid_out (pixel_valid_out),
    .winner_idx      (winner_idx),
    .winner_hit      (winner_hit),
    .collision_flags (collision_flags),
    .frame_done      (frame_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];   // {due cycle, hit, idx, rgb}
  logic [FW-1:0] flag_q[$];  // {due cycle, flags}
  logic [N-1:0]  acc_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Applies one pixel after the next rising edge and records what the
  // specification says must come out of it.
  task automatic drive_pixel(input logic v, input logic s, input logic [N-1:0] req,
                             input logic [N-1:0] en, input logic [N*CW-1:0] rgb,
                             input logic [CW-1:0] bg);
    logic [N-1:0]  act;
    logic [CW-1:0] exp_rgb;
    int            w;
    int            cnt;
    bit            found;
    @(posedge clk);
    #1;
    pixel_valid_in = v;
    start_of_frame = s;
    draw_req       = req;
    layer_en       = en;
    rgb_in         = rgb;
    bg_rgb         = bg;
    act   = '0;
    cnt   = 0;
    w     = 0;
    found = 0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && en[i] && (rgb[i*CW +: CW] != TRANS)) begin
        act[i] = 1'b1;
        cnt++;
        if (!found) begin
          found = 1;
          w     = i;
        end
      end
    end
    exp_rgb = found ? rgb[w*CW +: CW] : bg;
    if (v) exp_q.push_back({32'(cyc + 2), found, IW'(w), exp_rgb});
    if (s) begin
      flag_q.push_back({32'(cyc + 2), acc_model});
      acc_model = (v && cnt >= 2) ? act : '0;
    end else if (v && cnt >= 2) begin
      acc_model = acc_model | act;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_pixel(1'b0, 1'b0, '0, '1, '0, '0);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && (exp_q.size() != 0 || flag_q.size() != 0); k++) @(posedge clk);
    @(negedge clk);
    check("pixel_queue_drained", 32'(exp_q.size()), 32'd0);
    check("frame_queue_drained", 32'(flag_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [FW-1:0] f;
    if (!reset) begin
      if (pixel_valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel_valid_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pixel_latency_cycle", 32'(cyc), e[EW-1 -: 32]);
          check("rgb_out", 32'(rgb_out), 32'(e[CW-1:0]));
          check("winner_idx", 32'(winner_idx), 32'(e[CW +: IW]));
          check("winner_hit", 32'(winner_hit), 32'(e[CW+IW]));
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
        e = exp_q.pop_front();
        check("missing_pixel_valid_out", 32'd0, 32'd1);
      end
      if (frame_done) begin
        if (flag_q.size() == 0) begin
          check("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          f = flag_q.pop_front();
          check("frame_done_cycle", 32'(cyc), f[FW-1 -: 32]);
          check("collision_flags", 32'(collision_flags), 32'(f[N-1:0]));
        end
      end else if (flag_q.size() != 0 && int'(flag_q[0][FW-1 -: 32]) < cyc) begin
        f = flag_q.pop_front();
        check("missing_frame_done", 32'd0, 32'd1);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rgb_out"}, 32'(rgb_out), 32'd0);
    check({tag, "_pixel_valid_out"}, 32'(pixel_valid_out), 32'd0);
    check({tag, "_winner_idx"}, 32'(winner_idx), 32'd0);
    check({tag, "_winner_hit"}, 32'(winner_hit), 32'd0);
    check({tag, "_collision_flags"}, 32'(collision_flags), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N*CW-1:0] r;
    logic [N-1:0]    en_cur;
    logic [N-1:0]    req;
    logic [CW-1:0]   bg;
    bit              s;

    reset          = 1'b1;
    pixel_valid_in = 1'b0;
    start_of_frame = 1'b0;
    draw_req       = '0;
    rgb_in         = '0;
    layer_en       = '1;
    bg_rgb         = '0;
    acc_model      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;

    // First frame start after reset publishes zeros.
    drive_pixel(1'b1, 1'b1, '0, '1, '0, 8'h00);

    // Priority: layers 2, 5, 7 drawing; layer 2 wins.
    r = '0;
    r[2*CW +: CW] = 8'h1C;
    r[5*CW +: CW] = 8'hE0;
    r[7*CW +: CW] = 8'h03;
    drive_pixel(1'b1, 1'b0, 8'b1010_0100, '1, r, 8'h00);

    // Transparency and enable: layer 0 transparent, layer 1 disabled, layer 3 wins.
    r = '0;
    r[0*CW +: CW] = 8'hFF;
    r[1*CW +: CW] = 8'h55;
    r[3*CW +: CW] = 8'h77;
    drive_pixel(1'b1, 1'b0, 8'b0000_1011, 8'b1111_1101, r, 8'h00);
    // Nothing active: background.
    drive_pixel(1'b1, 1'b0, 8'h00, '1, r, 8'h10);
    drive_pixel(1'b1, 1'b0, 8'hFF, 8'h00, r, 8'h10);

    // Collision frame: layers 1 and 4 overlap once.
    drive_pixel(1'b1, 1'b1, '0, '1, '0, 8'h00);
    r = '0;
    r[1*CW +: CW] = 8'h11;
    r[4*CW +: CW] = 8'h44;
    drive_pixel(1'b1, 1'b0, 8'b0001_0010, '1, r, 8'h00);
    idle(18);
    // Frame start pixel itself overlaps layers 0 and 6: belongs to the new frame.
    r = '0;
    r[0*CW +: CW] = 8'h01;
    r[6*CW +: CW] = 8'h66;
    drive_pixel(1'b1, 1'b1, 8'b0100_0001, '1, r, 8'h20);
    // Invalid pixel with an overlap contributes nothing.
    r = '0;
    r[2*CW +: CW] = 8'h22;
    r[3*CW +: CW] = 8'h33;
    drive_pixel(1'b0, 1'b0, 8'b0000_1100, '1, r, 8'h00);
    idle(5);
    drive_pixel(1'b1, 1'b1, '0, '1, '0, 8'h00);
    // Back-to-back frame starts; the second carries only the first pixel's overlap.
    r = '0;
    r[1*CW +: CW] = 8'h12;
    r[2*CW +: CW] = 8'h34;
    drive_pixel(1'b1, 1'b1, 8'b0000_0110, '1, r, 8'h00);
    // Frame start with an invalid pixel still publishes.
    drive_pixel(1'b0, 1'b1, '0, '1, '0, 8'h00);

    // Mid-frame reset with a non-empty accumulator.
    r = '0;
    r[4*CW +: CW] = 8'h40;
    r[5*CW +: CW] = 8'h50;
    drive_pixel(1'b1, 1'b0, 8'b0011_0000, '1, r, 8'h00);
    idle(4);
    drain();
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset     = 1'b0;
    acc_model = '0;
    drive_pixel(1'b1, 1'b1, '0, '1, '0, 8'h00);
    idle(3);
    drain();

    // Random streaming: back-to-back valid pixels with occasional frame starts.
    en_cur = '1;
    for (int p = 0; p < 1000; p++) begin
      if (p % 100 == 50) en_cur = N'($urandom | $urandom);
      for (int i = 0; i < N; i++) begin
        r[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? TRANS : CW'($urandom_range(0, 255));
      end
      req = N'($urandom & $urandom);
      bg  = CW'($urandom_range(0, 255));
      s   = ($urandom_range(0, 49) == 0);
      drive_pixel(1'b1, s, req, en_cur, r, bg);
    end
    drive_pixel(1'b1, 1'b1, '0, '1, '0, 8'h00);
    idle(4);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layered_objects_mux.md
Name: layered_objects_mux

Overview:
- Parametrised successor to the fixed holes/borders/board priority mux.
- Selects the highest-priority active layer for each pixel. Index 0 is the highest priority.
- Adds per-layer enable, transparent-colour keying, a programmable background, a 2-stage pipeline with a valid flag, and per-frame overlap (collision) flags for game logic such as ball/hole hits.
- Sits between the object drawers and the VGA output stage.

Parameters:
- N_LAYERS, 8, number of drawing layers (2..16).
- COLOR_W, 8, pixel colour width.
- TRANSPARENT_RGB, 8'hFF, colour treated as "not drawn" even when the request is high.
- IDX_W, $clog2(N_LAYERS), width of winner index.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pixel_valid_in  in  1  current pixel inputs are valid.
- start_of_frame  in  1  one-cycle pulse, coincident with the first pixel of a frame.
- draw_req  in  N_LAYERS  per-layer drawing request.
- rgb_in  in  N_LAYERS*COLOR_W  packed layer colours; layer i occupies bits [i*COLOR_W +: COLOR_W].
- layer_en  in  N_LAYERS  per-layer enable, quasi-static.
- bg_rgb  in  COLOR_W  colour output when no layer is active.
- rgb_out  out  COLOR_W  selected colour.
- pixel_valid_out  out  1  rgb_out is valid.
- winner_idx  out  IDX_W  index of the winning layer; 0 when none wins.
- winner_hit  out  1  a layer won, i.e. the output is not background.
- collision_flags  out  N_LAYERS  bit i set if layer i was active together with at least one other layer during the previous frame.
- frame_done  out  1  one-cycle pulse when collision_flags updates.

Behaviour:
- Reset: asynchronous, active-high. All outputs, pipeline registers and the accumulator go to 0 immediately. A reset asserted mid-frame discards accumulated overlaps; collision_flags stays 0 until the next start_of_frame completes.
- Layer active condition: active[i] = draw_req[i] & layer_en[i] & (rgb_in slice i != TRANSPARENT_RGB).
- Stage 1, registered:
  - captures active, rgb_in, bg_rgb, pixel_valid_in and start_of_frame;
  - computes multi = (popcount(active) >= 2).
- Stage 2, registered:
  - priority-encodes the lowest active index;
  - rgb_out = rgb of the winning layer, else bg_rgb;
  - winner_hit = |active;
  - winner_idx = the encoded index, else 0;
  - pixel_valid_out = stage-1 valid.
- Latency: exactly 2 clk cycles from input to rgb_out, pixel_valid_out, winner_idx and winner_hit. Throughput is 1 pixel per cycle; there is no stall or back-pressure.
- Invalid pixels: when pixel_valid_in = 0, rgb_out is still computed, but the pixel does not contribute to collision accumulation.
- Collision accumulator: acc[N_LAYERS], updated in stage 2 from stage-1 values.
  - Normal cycle: if valid & multi, acc |= active.
  - Stage-1 start_of_frame = 1:
    - collision_flags <= acc (contributions from before this pixel only);
    - frame_done <= 1;
    - acc <= (valid & multi) ? active : 0, because this pixel belongs to the new frame.
  - Otherwise frame_done <= 0.
  - collision_flags therefore updates, and frame_done pulses, 2 cycles after start_of_frame is sampled. Flags hold until the next frame_done.
- Back-to-back start_of_frame pulses: each pulse publishes the accumulator and clears it; the second publish carries only the first pixel's overlap.
- The first start_of_frame after reset publishes all zeros.
- A start_of_frame sampled with pixel_valid_in = 0 still publishes and clears the accumulator.
- layer_en changes take effect on the next sampled pixel, with no glitch handling required.
- Width rule: the popcount is internal only, saturating at 2; no overflow is possible.

Decomposition:
- Package objects_mux_pkg holds:
  - COLOR_W default (8);
  - TRANSPARENT_RGB default (8'hFF);
  - BLACK_RGB (8'h00);
  - a function rgb_slice(packed, idx).
- Sub-module layer_priority_encoder: combinational, N_LAYERS-parameterised. Inputs: active vector. Outputs: idx[IDX_W] and hit.

Test Plan:
- Reset during operation (reset=1 mid-frame with acc nonzero) -> all outputs 0 the same cycle, asynchronously; the next frame_done publishes collision_flags=0.
- Priority, N_LAYERS=8: draw_req=8'b1010_0100, rgb_in layer2=8'h1C, layer5=8'hE0, layer7=8'h03, all enabled -> 2 cycles later rgb_out=8'h1C, winner_idx=2, winner_hit=1, pixel_valid_out=1.
- Transparency/enable: layer0 rgb=8'hFF with req=1; layer1 req=1, rgb=8'h55, layer_en[1]=0; layer3 req=1, rgb=8'h77 -> rgb_out=8'h77, winner_idx=3; with all inactive and bg_rgb=8'h10 -> rgb_out=8'h10, winner_hit=0, winner_idx=0.
- Collision frame: pulse start_of_frame; one valid pixel with layers 1 and 4 active; pulse start_of_frame 20 cycles later -> frame_done high exactly 2 cycles after the second pulse, collision_flags=8'b0001_0010.
- Boundary: the pixel coincident with start_of_frame has layers 0 and 6 active -> current publish excludes bits 0/6; the next publish includes 8'b0100_0001. A valid=0 pixel with overlap contributes nothing.
- Streaming: 1000 random valid pixels back-to-back against a reference model -> rgb_out, winner_idx and winner_hit match with exact 2-cycle latency, with no bubbles.
